// File: rtl/io_write_arbiter.sv
// Two-requester write-bus arbiter: round-robin selection with bounded burst locking,
// winning write driven onto the bus as a registered single-cycle strobe.
module io_write_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic              req0_lock_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    input  logic              req1_lock_i,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_address_o,
    output logic [DATA_W-1:0] bus_data_in_o,
    output logic              grant_id_o,
    output logic              locked_o
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    // Count value at which the current locked transfer is the final one of the burst.
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);
    localparam bit LockEnable = (MAX_BURST > 1);

    typedef enum logic {StArb, StLocked} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_address_q, bus_address_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;

    logic xfer, winner, win_lock;

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (!reset_i) begin
            case (state_q)
                StArb: begin
                    if (req0_valid_i && req1_valid_i) begin
                        req0_ready_o = last_grant_q;
                        req1_ready_o = !last_grant_q;
                    end else begin
                        req0_ready_o = req0_valid_i;
                        req1_ready_o = req1_valid_i;
                    end
                end
                StLocked: begin
                    req0_ready_o = req0_valid_i && !last_grant_q;
                    req1_ready_o = req1_valid_i && last_grant_q;
                end
                default: ;
            endcase
        end
    end

    assign winner   = req1_valid_i && req1_ready_o;
    assign xfer     = (req0_valid_i && req0_ready_o) || winner;
    assign win_lock = winner ? req1_lock_i : req0_lock_i;

    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        bus_we_d      = xfer;
        bus_address_d = bus_address_q;
        bus_data_d    = bus_data_q;

        if (xfer) begin
            last_grant_d  = winner;
            grant_id_d    = winner;
            bus_address_d = winner ? req1_addr_i : req0_addr_i;
            bus_data_d    = winner ? req1_data_i : req0_data_i;
        end

        case (state_q)
            StArb: begin
                if (xfer && win_lock && LockEnable) begin
                    state_d     = StLocked;
                    burst_cnt_d = CntW'(1);
                end
            end
            StLocked: begin
                // An idle owner or an exhausted burst both release the lock.
                if (xfer && win_lock && (burst_cnt_q < LastBeat)) begin
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end else begin
                    state_d     = StArb;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = StArb;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StArb;
            burst_cnt_q   <= '0;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_address_q <= '0;
            bus_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            bus_we_q      <= bus_we_d;
            bus_address_q <= bus_address_d;
            bus_data_q    <= bus_data_d;
        end
    end

    assign bus_we_o      = bus_we_q;
    assign bus_address_o = bus_address_q;
    assign bus_data_in_o = bus_data_q;
    assign grant_id_o    = grant_id_q;
    assign locked_o      = (state_q == StLocked);

endmodule

// File: tb/tb_io_write_arbiter.sv
// Bench for io_write_arbiter: directed scenarios plus random traffic, checked by a
// rule-level arbitration model feeding a scoreboard of expected bus writes.
module tb_io_write_arbiter;

    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0, v1, r0, r1, l0, l1;
    logic [7:0] a0, a1, d0, d1;
    logic       bus_we, grant_id, locked;
    logic [7:0] bus_address, bus_data_in;

    always #5 clk = ~clk;

    io_write_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MB)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req0_valid_i (v0),
        .req0_ready_o (r0),
        .req0_addr_i  (a0),
        .req0_data_i  (d0),
        .req0_lock_i  (l0),
        .req1_valid_i (v1),
        .req1_ready_o (r1),
        .req1_addr_i  (a1),
        .req1_data_i  (d1),
        .req1_lock_i  (l1),
        .bus_we_o     (bus_we),
        .bus_address_o(bus_address),
        .bus_data_in_o(bus_data_in),
        .grant_id_o   (grant_id),
        .locked_o     (locked)
    );

    typedef struct {
        int         due;
        logic [7:0] addr;
        logic [7:0] data;
        logic       id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    // Reference model: who was last served, and how many locked beats the owner has used.
    int   m_owner = 1;
    int   m_gid   = 0;
    int   m_beats = 0;
    bit   acc0, acc1;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("bus_we", int'(bus_we), 1);
                chk("bus_address", int'(bus_address), int'(mon_e.addr));
                chk("bus_data_in", int'(bus_data_in), int'(mon_e.data));
                chk("bus_grant_id", int'(grant_id), int'(mon_e.id));
            end else begin
                chk("bus_we_idle", int'(bus_we), 0);
            end
        end
    end

    task automatic step();
        bit e0, e1, w, wl;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!reset) begin
            if (m_beats > 0) begin
                e0 = v0 && (m_owner == 0);
                e1 = v1 && (m_owner == 1);
            end else if (v0 && v1) begin
                e0 = (m_owner == 1);
                e1 = (m_owner == 0);
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        chk("req0_ready", int'(r0), int'(e0));
        chk("req1_ready", int'(r1), int'(e1));
        chk("locked", int'(locked), int'(m_beats > 0));
        chk("grant_id", int'(grant_id), m_gid);
        w  = e1;
        wl = w ? l1 : l0;
        if (e0 || e1) sb.push_back('{due: cyc + 1, addr: (w ? a1 : a0),
                                     data: (w ? d1 : d0), id: w});
        acc0 = e0;
        acc1 = e1;
        @(posedge clk);
        if (reset) begin
            m_owner = 1;
            m_gid   = 0;
            m_beats = 0;
        end else if (e0 || e1) begin
            m_owner = int'(w);
            m_gid   = int'(w);
            m_beats = (wl && (m_beats + 1 < int'(MB))) ? m_beats + 1 : 0;
        end else begin
            m_beats = 0;
        end
        #1;
    endtask

    task automatic set0(bit v, bit [7:0] a, bit [7:0] d, bit l);
        v0 = v; a0 = a; d0 = d; l0 = l;
    endtask

    task automatic set1(bit v, bit [7:0] a, bit [7:0] d, bit l);
        v1 = v; a1 = a; d1 = d; l1 = l;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set0(0, 8'h00, 8'h00, 0);
        set1(0, 8'h00, 8'h00, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        // Single write from requester 0.
        set0(1, 8'hE0, 8'h5A, 0);
        step();
        set0(0, 8'hE0, 8'h5A, 0);
        repeat (2) step();

        // Continuous contention without locking alternates 0,1,0,1.
        do_reset();
        set0(1, 8'hE0, 8'h11, 0);
        set1(1, 8'hE1, 8'h22, 0);
        repeat (6) step();

        // Held lock is capped at MB beats.
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        do_reset();
        set0(1, 8'hE0, 8'h33, 1);
        set1(1, 8'hE1, 8'h44, 0);
        repeat (7) step();

        // Lock released early by lock=0 on the second beat.
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        do_reset();
        set0(1, 8'hE0, 8'h55, 1);
        set1(1, 8'hE1, 8'h66, 0);
        step();
        set0(1, 8'hE0, 8'h56, 0);
        repeat (3) step();

        // Owner idles during a lock: no transfer, then requester 1 wins.
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        do_reset();
        set0(1, 8'hE0, 8'h77, 1);
        set1(1, 8'hE1, 8'h88, 0);
        step();
        set0(0, 8'hE0, 8'h77, 1);
        step();
        set0(1, 8'hE0, 8'h78, 1);
        repeat (3) step();

        // Reset pulsed mid-burst.
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        do_reset();
        set0(1, 8'hE0, 8'h99, 1);
        set1(0, 8'hE1, 8'hAA, 0);
        repeat (2) step();
        do_reset();
        set0(1, 8'hE0, 8'h9A, 0);
        set1(1, 8'hE1, 8'hAB, 0);
        repeat (3) step();

        // Random traffic; pending requests hold their payload until accepted.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (!(v0 && !acc0) || $urandom_range(0, 9) == 0)
                set0(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)));
            if (!(v1 && !acc1) || $urandom_range(0, 9) == 0)
                set1(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)));
            step();
        end

        reset = 1'b0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
